// File: rtl/onehot_rr_scheduler_if.sv
// Scheduler handshake bundle: requests/done in, one-hot grant and status out.
// The scheduler uses the master view; the requester side uses the slave view.
interface onehot_rr_scheduler_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout_flag;

  modport master (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout_flag
  );

  modport slave (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout_flag
  );
endinterface

// File: rtl/onehot_rr_scheduler.sv
// Round-robin scheduler for 8 requesters with held one-hot grant and binary index.
// Optional grant-hold timeout is enabled by defining SCHED_TIMEOUT_EN.
module onehot_rr_scheduler #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                    clk,
  input logic                    rst,
  onehot_rr_scheduler_if.master  bus
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  typedef logic [IW-1:0] idx_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("onehot_rr_scheduler: TIMEOUT must be in 1..255");
  end

  state_t         state, state_n;
  idx_t           ptr, ptr_n;
  logic [N-1:0]   grant_q, grant_n;
  idx_t           idx_q, idx_n;
  logic           valid_q, valid_n;

  logic           found;
  idx_t           sel_idx;
  idx_t           cand;

`ifdef SCHED_TIMEOUT_EN
  logic [7:0]     cnt, cnt_n;
  logic [7:0]     cnt_inc;
  logic           flag_q, flag_n;
`endif

  // Upward search from ptr with wrap; first hit wins.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + idx_t'(k);
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  assign cnt_inc = cnt + 8'd1;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant_q;
    idx_n   = idx_q;
    valid_n = valid_q;
`ifdef SCHED_TIMEOUT_EN
    cnt_n   = cnt;
    flag_n  = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (found) begin
          grant_n = N'(1) << sel_idx;
          idx_n   = sel_idx;
          valid_n = 1'b1;
          ptr_n   = sel_idx + idx_t'(1);
          state_n = S_GRANT;
`ifdef SCHED_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      S_GRANT: begin
        if (bus.done) begin
          grant_n = '0;
          idx_n   = '0;
          valid_n = 1'b0;
          state_n = S_IDLE;
        end
`ifdef SCHED_TIMEOUT_EN
        // done has priority: revoke by timeout only when done is absent.
        else if (cnt_inc == 8'(TIMEOUT)) begin
          grant_n = '0;
          idx_n   = '0;
          valid_n = 1'b0;
          flag_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n   = cnt_inc;
        end
`endif
      end
      default: begin
        state_n = S_IDLE;
        grant_n = '0;
        idx_n   = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      cnt     <= '0;
      flag_q  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      grant_q <= grant_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
`ifdef SCHED_TIMEOUT_EN
      cnt     <= cnt_n;
      flag_q  <= flag_n;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
`ifdef SCHED_TIMEOUT_EN
  assign bus.timeout_flag = flag_q;
`else
  assign bus.timeout_flag = 1'b0;
`endif

  a_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_valid   : assert property (@(posedge clk) disable iff (rst) valid_q == (grant_q != '0));
  a_index   : assert property (@(posedge clk) disable iff (rst)
                               valid_q |-> grant_q[idx_q]);

endmodule
